// File: rtl/char_console_writer.sv
// Text-console engine: turns character-interface requests into text RAM writes,
// handling control codes, line wrap, whole-screen clear, row clear and scrolling.
module char_console_writer #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 25,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned COL_W  = 6,
  parameter int unsigned ROW_W  = 5
) (
  input  logic              system_clock,
  input  logic              hardware_reset,
  input  logic              char_write,
  input  logic [7:0]        char_out,
  input  logic              char_clear,
  input  logic              char_clear_line,
  output logic              char_done,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL_A = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_N_A  = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [7:0]        SPACE       = 8'h20;
  localparam logic [7:0]        CODE_CR     = 8'h0D;
  localparam logic [7:0]        CODE_LF     = 8'h0A;
  localparam logic [7:0]        CODE_BS     = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_CLEAR,
    S_CLEAR_LINE,
    S_SCROLL,
    S_SCROLL_FILL,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              adv_q;
  logic              we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              done_q;
  logic              busy_q;

  logic [ADDR_W-1:0] row_base_d;
  logic [ADDR_W-1:0] cur_addr_d;

  assign row_base_d = ADDR_W'(row_q) * COLS_A;
  assign cur_addr_d = row_base_d + ADDR_W'(col_q);

  // Outputs are registered together with the state they belong to, so a
  // write is visible exactly while the FSM sits in the writing state.
  // Outside SCROLL the read port idles on COLS so the first scroll read is
  // already in flight when SCROLL is entered.
  always_ff @(posedge system_clock or negedge hardware_reset) begin
    if (!hardware_reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      adv_q     <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= SPACE;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      rd_addr_q <= COLS_A;
      unique case (state_q)
        S_IDLE: begin
          if (char_clear) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            we_q      <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= SPACE;
          end else if (char_clear_line) begin
            state_q   <= S_CLEAR_LINE;
            cnt_q     <= '0;
            we_q      <= 1'b1;
            wr_addr_q <= row_base_d;
            wr_data_q <= SPACE;
          end else if (char_write) begin
            case (char_out)
              CODE_CR: begin
                col_q   <= '0;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
              CODE_LF: begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                  state_q   <= S_SCROLL;
                  cnt_q     <= '0;
                  rd_addr_q <= COLS_A + 1'b1;
                end else begin
                  row_q   <= row_q + 1'b1;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
              CODE_BS: begin
                if (col_q != '0) begin
                  col_q     <= col_q - 1'b1;
                  state_q   <= S_PUT;
                  adv_q     <= 1'b0;
                  we_q      <= 1'b1;
                  wr_addr_q <= cur_addr_d - 1'b1;
                  wr_data_q <= SPACE;
                end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
              default: begin
                state_q   <= S_PUT;
                adv_q     <= 1'b1;
                we_q      <= 1'b1;
                wr_addr_q <= cur_addr_d;
                wr_data_q <= char_out;
              end
            endcase
          end else begin
            busy_q <= 1'b0;
          end
        end

        S_PUT: begin
          if (adv_q && (col_q == COL_LAST)) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              state_q   <= S_SCROLL;
              cnt_q     <= '0;
              rd_addr_q <= COLS_A + 1'b1;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            if (adv_q) begin
              col_q <= col_q + 1'b1;
            end
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_CLEAR: begin
          if (cnt_q == LAST_CELL_A) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            we_q      <= 1'b1;
            wr_addr_q <= cnt_q + 1'b1;
          end
        end

        S_CLEAR_LINE: begin
          if (cnt_q == COLS_A - 1'b1) begin
            col_q   <= '0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            we_q      <= 1'b1;
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end

        // Cycle k holds the data of cell COLS+k and writes it to cell k next cycle.
        S_SCROLL: begin
          if (cnt_q == SCROLL_N_A) begin
            state_q   <= S_SCROLL_FILL;
            cnt_q     <= '0;
            we_q      <= 1'b1;
            wr_addr_q <= SCROLL_N_A;
            wr_data_q <= SPACE;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            we_q      <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= ram_rd_data;
            rd_addr_q <= (rd_addr_q == LAST_CELL_A) ? rd_addr_q : rd_addr_q + 1'b1;
          end
        end

        S_SCROLL_FILL: begin
          if (cnt_q == COLS_A - 1'b1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            we_q      <= 1'b1;
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign char_done   = done_q;
  assign ram_we      = we_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;
  assign busy        = busy_q;

endmodule
